// File: rtl/sbs_nrzi_tx_pkg.sv
// Shared types and constants for the transmit bit stuffer / NRZI encoder.
package sbs_nrzi_tx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int unsigned STUFF_LEN_DEFAULT = 6;
  localparam logic        IDLE_LEVEL        = 1'b1;

endpackage

// File: rtl/sbs_nrzi_tx_flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover value.
module sbs_nrzi_tx_flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_next;
  logic                    flag_next;

  always_comb begin
    count_next = count_out;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_next = NUM_CNT_BITS'(1);
      end else begin
        count_next = count_out + NUM_CNT_BITS'(1);
      end
    end
    flag_next = (count_next == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_next;
      rollover_flag <= flag_next;
    end
  end

endmodule

// File: rtl/sbs_nrzi_tx.sv
// Transmit bit stuffer and NRZI line encoder: inserts a 0 after STUFF_LEN
// consecutive 1s (stalling upstream for that strobe) and drives the line.
module sbs_nrzi_tx
  import sbs_nrzi_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       shift_enable,
  input  logic       tx_active,
  input  logic       tx_bit,
  output logic       bit_req,
  output logic       d_encoded,
  output logic       stuff_pending,
  output logic [7:0] stuff_cnt
);

  localparam logic [CNT_W-1:0] STUFF_LIMIT = CNT_W'(STUFF_LEN);

  state_t             state_reg;
  logic [CNT_W-1:0]   ones;
  logic               ones_rollover_unused;
  logic               in_active;
  logic               at_limit;
  logic               stuff_emit;
  logic               go_idle;
  logic               ones_inc;
  logic               ones_clr;

  assign in_active  = (state_reg == ACTIVE);
  assign at_limit   = (ones == STUFF_LIMIT);

  // A pending stuff bit wins over data and over end-of-packet.
  assign stuff_emit    = shift_enable & in_active & at_limit;
  assign bit_req       = shift_enable & tx_active & ~(in_active & at_limit);
  assign go_idle       = shift_enable & in_active & ~at_limit & ~tx_active;
  assign stuff_pending = in_active & at_limit;

  assign ones_inc = bit_req & tx_bit;
  assign ones_clr = (bit_req & ~tx_bit) | stuff_emit | go_idle;

  sbs_nrzi_tx_flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_ones_cnt (
    .clk          (clk),
    .n_rst        (nrst),
    .clear        (ones_clr),
    .count_enable (ones_inc),
    .rollover_val (STUFF_LIMIT),
    .count_out    (ones),
    .rollover_flag(ones_rollover_unused)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      d_encoded <= IDLE_LEVEL;
      stuff_cnt <= 8'd0;
    end else if (stuff_emit) begin
      d_encoded <= ~d_encoded;
      if (stuff_cnt != 8'hFF) begin
        stuff_cnt <= stuff_cnt + 8'd1;
      end
    end else if (bit_req) begin
      // In IDLE the line already sits at the idle level, so the first bit
      // is naturally encoded against 1.
      if (!in_active) begin
        state_reg <= ACTIVE;
        stuff_cnt <= 8'd0;
      end
      if (!tx_bit) begin
        d_encoded <= ~d_encoded;
      end
    end else if (go_idle) begin
      state_reg <= IDLE;
      d_encoded <= IDLE_LEVEL;
    end
  end

endmodule
